// File: rtl/commit_trace_rx_if.sv
// commit_trace_rx_if: commit capture inputs and record/status outputs of commit_trace_rx.
interface commit_trace_rx_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned SEQ_W = 32
);
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic             update_i;
   logic [XLEN-1:0]  pc_i;
   logic [XLEN-1:0]  instr_i;
   logic [4:0]       reg_addr_i;
   logic [XLEN-1:0]  reg_data_i;
   logic             rec_valid_o;
   logic             rec_ready_i;
   logic [SEQ_W-1:0] rec_seq_o;
   logic [XLEN-1:0]  rec_pc_o;
   logic [XLEN-1:0]  rec_instr_o;
   logic [4:0]       rec_rd_o;
   logic [XLEN-1:0]  rec_rd_data_o;
   logic [LW-1:0]    level_o;
   logic             overflow_o;
   logic [SEQ_W-1:0] drop_cnt_o;
   logic             done_o;

   modport master (
      output update_i, pc_i, instr_i, reg_addr_i, reg_data_i, rec_ready_i,
      input  rec_valid_o, rec_seq_o, rec_pc_o, rec_instr_o, rec_rd_o, rec_rd_data_o,
      input  level_o, overflow_o, drop_cnt_o, done_o
   );

   modport slave (
      input  update_i, pc_i, instr_i, reg_addr_i, reg_data_i, rec_ready_i,
      output rec_valid_o, rec_seq_o, rec_pc_o, rec_instr_o, rec_rd_o, rec_rd_data_o,
      output level_o, overflow_o, drop_cnt_o, done_o
   );
endinterface

// File: rtl/commit_trace_rx.sv
// commit_trace_rx: buffers core commit records in a show-ahead FIFO tagged with sequence numbers.
// Optional macro TRACE_DEDUP_EN discards repeated pc/instr pairs from stalled update pulses.
module commit_trace_rx #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned SEQ_W = 32
) (
   input logic              clk_i,
   input logic              rst_i,
   commit_trace_rx_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

   typedef struct packed {
      logic [SEQ_W-1:0] seq;
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  instr;
      logic [4:0]       rd;
      logic [XLEN-1:0]  data;
   } rec_t;

   rec_t             mem_q [DEPTH];
   rec_t             head;
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]    level_q, level_d;
   logic [SEQ_W-1:0] seq_q, drop_cnt_q;
   logic             overflow_q;
   state_e           state_q, state_d;
   logic             upd_run, is_halt, dup, push_req, push, pop, drop, valid;

`ifdef TRACE_DEDUP_EN
   logic            last_vld_q;
   logic [XLEN-1:0] last_pc_q, last_instr_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_vld_q   <= 1'b0;
         last_pc_q    <= '0;
         last_instr_q <= '0;
      end else if (push) begin
         last_vld_q   <= 1'b1;
         last_pc_q    <= bus.pc_i;
         last_instr_q <= bus.instr_i;
      end
   end

   assign dup = last_vld_q && (bus.pc_i == last_pc_q) && (bus.instr_i == last_instr_q);
`else
   assign dup = 1'b0;
`endif

   assign valid = (level_q != '0);

   always_comb begin
      upd_run  = bus.update_i && (state_q == StRun);
      is_halt  = (bus.instr_i == XLEN'(32'h0000_0073)) || (bus.instr_i == XLEN'(32'h0010_0073)) ||
                 (bus.instr_i == XLEN'(32'h0000_006F));
      pop      = valid && bus.rec_ready_i;
      push_req = upd_run && !dup;
      // A full FIFO still takes a push when the head leaves on the same edge.
      push     = push_req && ((level_q != LW'(DEPTH)) || pop);
      drop     = push_req && !push;
      level_d  = level_q + LW'(push) - LW'(pop);
      state_d  = state_q;
      case (state_q)
         StRun:    if (upd_run && is_halt) state_d = StDrain;
         StDrain:  if (level_d == '0) state_d = StHalted;
         StHalted: state_d = StHalted;
         default:  state_d = StRun;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StRun;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         seq_q      <= '0;
         drop_cnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         level_q  <= level_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            seq_q    <= seq_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{seq: seq_q, pc: bus.pc_i, instr: bus.instr_i,
                              rd: bus.reg_addr_i, data: bus.reg_data_i};
      end
   end

   assign head              = mem_q[rd_ptr_q];
   assign bus.rec_valid_o   = valid;
   assign bus.rec_seq_o     = valid ? head.seq : '0;
   assign bus.rec_pc_o      = valid ? head.pc : '0;
   assign bus.rec_instr_o   = valid ? head.instr : '0;
   assign bus.rec_rd_o      = valid ? head.rd : '0;
   assign bus.rec_rd_data_o = (valid && (head.rd != '0)) ? head.data : '0;
   assign bus.level_o       = level_q;
   assign bus.overflow_o    = overflow_q;
   assign bus.drop_cnt_o    = drop_cnt_q;
   assign bus.done_o        = (state_q == StHalted);
endmodule

// File: tb/tb_commit_trace_rx.sv
// tb_commit_trace_rx: table vectors, directed corner sequences and random traffic vs a queue model.
module tb_commit_trace_rx;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned SEQ_W = 32;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] ADDI   = 32'h00a0_0093;
   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] JSELF  = 32'h0000_006F;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   commit_trace_rx_if #(.XLEN(XLEN), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) bus ();

   commit_trace_rx #(.XLEN(XLEN), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: a queue of records plus a three-way mode (0 run, 1 drain, 2 halted).
   typedef struct {
      logic [31:0] seq;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic [31:0] data;
   } mrec_t;

   mrec_t       mq[$];
   int unsigned m_seq, m_drops;
   bit          m_ovf, m_last_vld;
   int          m_mode;
   logic [31:0] m_last_pc, m_last_instr;

   task automatic model_edge();
      bit    pop, dup, do_push;
      int    old_mode;
      mrec_t r;
      if (rst) begin
         mq.delete();
         m_seq = 0; m_drops = 0; m_ovf = 0; m_mode = 0; m_last_vld = 0;
         return;
      end
      old_mode = m_mode;
      pop      = (mq.size() != 0) && bus.rec_ready_i;
      do_push  = 0;
      if (m_mode == 0 && bus.update_i) begin
         dup = 0;
`ifdef TRACE_DEDUP_EN
         dup = m_last_vld && bus.pc_i == m_last_pc && bus.instr_i == m_last_instr;
`endif
         if (!dup) begin
            if (mq.size() < DEPTH || pop) do_push = 1;
            else begin
               m_ovf = 1;
               if (m_drops != 32'hFFFF_FFFF) m_drops++;
            end
         end
         if (bus.instr_i == ECALL || bus.instr_i == EBREAK || bus.instr_i == JSELF) m_mode = 1;
      end
      if (pop) void'(mq.pop_front());
      if (do_push) begin
         r = '{seq: m_seq, pc: bus.pc_i, instr: bus.instr_i, rd: bus.reg_addr_i,
               data: bus.reg_data_i};
         mq.push_back(r);
         m_seq++;
         m_last_vld = 1; m_last_pc = bus.pc_i; m_last_instr = bus.instr_i;
      end
      if (old_mode == 1 && mq.size() == 0) m_mode = 2;
   endtask

   task automatic compare_model(input string tag);
      mrec_t h;
      h = '{seq: 0, pc: 0, instr: 0, rd: 0, data: 0};
      if (mq.size() != 0) h = mq[0];
      chk({tag, " valid"}, bus.rec_valid_o, mq.size() != 0);
      chk({tag, " seq"}, bus.rec_seq_o, h.seq);
      chk({tag, " pc"}, bus.rec_pc_o, h.pc);
      chk({tag, " instr"}, bus.rec_instr_o, h.instr);
      chk({tag, " rd"}, bus.rec_rd_o, h.rd);
      chk({tag, " rd_data"}, bus.rec_rd_data_o, (h.rd == 0) ? 32'h0 : h.data);
      chk({tag, " level"}, bus.level_o, mq.size());
      chk({tag, " overflow"}, bus.overflow_o, m_ovf);
      chk({tag, " drop_cnt"}, bus.drop_cnt_o, m_drops);
      chk({tag, " done"}, bus.done_o, m_mode == 2);
   endtask

   task automatic tick(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      compare_model(tag);
   endtask

   task automatic drive(input bit upd, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [4:0] rd, input logic [31:0] data, input bit ready);
      bus.update_i    = upd;
      bus.pc_i        = pc;
      bus.instr_i     = instr;
      bus.reg_addr_i  = rd;
      bus.reg_data_i  = data;
      bus.rec_ready_i = ready;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
      tick("reset");
      rst = 1'b0;
   endtask

   typedef struct {
      bit          upd;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] data;
      bit          ready;
      bit          e_valid;
      logic [31:0] e_seq;
      logic [31:0] e_pc;
      logic [4:0]  e_rd;
      logic [31:0] e_rdd;
      logic [3:0]  e_level;
   } vec_t;

   vec_t tbl[4];

   initial begin
      tbl[0] = '{1'b1, 32'h8000_0000, 5'd5, 32'h1111, 1'b1,
                 1'b1, 32'd0, 32'h8000_0000, 5'd5, 32'h1111, 4'd1};
      tbl[1] = '{1'b1, 32'h8000_0004, 5'd0, 32'h2222, 1'b1,
                 1'b1, 32'd1, 32'h8000_0004, 5'd0, 32'h0, 4'd1};
      tbl[2] = '{1'b1, 32'h8000_0008, 5'd7, 32'h3333, 1'b1,
                 1'b1, 32'd2, 32'h8000_0008, 5'd7, 32'h3333, 4'd1};
      tbl[3] = '{1'b0, 32'h0, 5'd0, 32'h0, 1'b1,
                 1'b0, 32'd0, 32'h0, 5'd0, 32'h0, 4'd0};

      do_reset();
      chk("reset valid", bus.rec_valid_o, 1'b0);
      chk("reset level", bus.level_o, 0);
      chk("reset done", bus.done_o, 1'b0);

      // Basic capture: each record appears one cycle after its push.
      for (int i = 0; i < 4; i++) begin
         drive(tbl[i].upd, tbl[i].pc, NOP, tbl[i].rd, tbl[i].data, tbl[i].ready);
         tick("tbl");
         chk($sformatf("tbl%0d valid", i), bus.rec_valid_o, tbl[i].e_valid);
         chk($sformatf("tbl%0d seq", i), bus.rec_seq_o, tbl[i].e_seq);
         chk($sformatf("tbl%0d pc", i), bus.rec_pc_o, tbl[i].e_pc);
         chk($sformatf("tbl%0d rd", i), bus.rec_rd_o, tbl[i].e_rd);
         chk($sformatf("tbl%0d rd_data", i), bus.rec_rd_data_o, tbl[i].e_rdd);
         chk($sformatf("tbl%0d level", i), bus.level_o, tbl[i].e_level);
      end

      // Overflow: ten pushes into eight slots, then drain in order.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'h100 + 32'(4 * i), NOP, 5'(i + 1), 32'(i), 1'b0);
         tick("ovf fill");
      end
      drive(1'b0, 32'h0, NOP, 5'd0, 32'h0, 1'b0);
      chk("ovf level", bus.level_o, 8);
      chk("ovf flag", bus.overflow_o, 1'b1);
      chk("ovf drop_cnt", bus.drop_cnt_o, 2);
      bus.rec_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("ovf out%0d seq", i), bus.rec_seq_o, i);
         chk($sformatf("ovf out%0d pc", i), bus.rec_pc_o, 32'h100 + 32'(4 * i));
         tick("ovf drain");
      end
      chk("ovf empty", bus.rec_valid_o, 1'b0);

      // Full with simultaneous push and pop.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'h300 + 32'(4 * i), NOP, 5'd3, 32'(i), 1'b0);
         tick("full fill");
      end
      drive(1'b1, 32'h200, NOP, 5'd9, 32'hABC, 1'b1);
      tick("full pushpop");
      chk("full level", bus.level_o, 8);
      chk("full drop_cnt", bus.drop_cnt_o, 0);
      chk("full head seq", bus.rec_seq_o, 1);
      drive(1'b0, 32'h0, NOP, 5'd0, 32'h0, 1'b1);
      for (int i = 0; i < 7; i++) tick("full drain");
      chk("full tail seq", bus.rec_seq_o, 8);
      chk("full tail pc", bus.rec_pc_o, 32'h200);
      chk("full tail data", bus.rec_rd_data_o, 32'hABC);

      // Halt then drain to done.
      do_reset();
      drive(1'b1, 32'h10, NOP, 5'd1, 32'h1, 1'b0);   tick("halt");
      drive(1'b1, 32'h14, NOP, 5'd2, 32'h2, 1'b0);   tick("halt");
      drive(1'b1, 32'h18, ECALL, 5'd0, 32'h3, 1'b0); tick("halt");
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h1C + 32'(4 * i), NOP, 5'd4, 32'h4, 1'b0);
         tick("halt ignored");
      end
      chk("halt level", bus.level_o, 3);
      chk("halt drop_cnt", bus.drop_cnt_o, 0);
      chk("halt done early", bus.done_o, 1'b0);
      drive(1'b0, 32'h0, NOP, 5'd0, 32'h0, 1'b1);
      tick("halt pop");
      tick("halt pop");
      chk("halt last seq", bus.rec_seq_o, 2);
      chk("halt last instr", bus.rec_instr_o, ECALL);
      chk("halt done pending", bus.done_o, 1'b0);
      tick("halt pop");
      chk("halt done", bus.done_o, 1'b1);
      chk("halt drained", bus.level_o, 0);

      // Reset in the middle of a drain, with overflow set by a dropped halt.
      do_reset();
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 32'h400 + 32'(4 * i), (i == 8) ? ECALL : NOP, 5'd1, 32'h5, 1'b0);
         tick("drain fill");
      end
      chk("drain overflow", bus.overflow_o, 1'b1);
      drive(1'b1, 32'h500, NOP, 5'd1, 32'h5, 1'b1);
      for (int i = 0; i < 4; i++) tick("drain pop");
      chk("drain level", bus.level_o, 4);
      do_reset();
      chk("midrst level", bus.level_o, 0);
      chk("midrst valid", bus.rec_valid_o, 1'b0);
      chk("midrst done", bus.done_o, 1'b0);
      chk("midrst overflow", bus.overflow_o, 1'b0);

      // Repeated pc/instr pulses.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h600, ADDI, 5'd1, 32'h7, 1'b0);
         tick("dedup");
      end
`ifdef TRACE_DEDUP_EN
      chk("dedup level", bus.level_o, 1);
`else
      chk("dedup level", bus.level_o, 3);
`endif
      chk("dedup head seq", bus.rec_seq_o, 0);

      // Random traffic against the model.
      do_reset();
      begin
         int rdy_bias;
         rdy_bias = 2;
         for (int c = 0; c < 3000; c++) begin
            logic [31:0] pc, instr;
            int          r;
            if (c % 200 == 0) rdy_bias = $urandom_range(0, 4);
            pc    = 32'h8000_0000 + ($urandom_range(0, 3) << 2);
            r     = $urandom_range(0, 199);
            instr = (r == 0) ? ECALL : (r == 1) ? EBREAK : (r == 2) ? JSELF :
                    r[0] ? NOP : ADDI;
            rst   = ($urandom_range(0, 299) == 0) || (m_mode == 2 && $urandom_range(0, 7) == 0);
            drive(1'($urandom_range(0, 1)), pc, instr, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 3) < rdy_bias);
            tick("rnd");
            rst = 1'b0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
